// File: rtl/frame_config_loader.sv
// Frame configuration loader: a sync word unlocks the loader, then each header
// selects a frame index and the following NumberOfRows words are latched and strobed out.
// The optional FramesWritten counter is enabled with `define FRAME_LOADER_FRAMECOUNT_EN.
module frame_config_loader #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumberOfRows    = 16
) (
  input  logic                                    CLK,
  input  logic                                    resetn,
  input  logic [FrameBitsPerRow-1:0]              WriteData,
  input  logic                                    WriteValid,
  output logic                                    WriteReady,
  output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]              FrameStrobe,
  output logic                                    ConfigBusy,
  output logic                                    ConfigDone,
  output logic                                    ConfigError
`ifdef FRAME_LOADER_FRAMECOUNT_EN
  ,
  output logic [15:0]                             FramesWritten
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HEADER = 2'd1;
  localparam logic [1:0] DATA   = 2'd2;
  localparam logic [1:0] STROBE = 2'd3;

  localparam int RowW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam logic [RowW-1:0] LAST_ROW = RowW'(NumberOfRows - 1);
  localparam logic [FrameBitsPerRow-1:0] SYNC_WORD = FrameBitsPerRow'(32'hFAB0_FAB1);

  logic [1:0]      state_q;
  logic [RowW-1:0] row_q;
  logic [4:0]      index_q;
  logic            index_ok_q;
  logic [NumberOfRows-1:0][FrameBitsPerRow-1:0] frame_rows_q;

  logic                       accept;
  logic                       is_sync;
  logic                       hdr_end;
  logic [4:0]                 hdr_index;
  logic                       hdr_index_ok;
  logic [MaxFramesPerCol-1:0] strobe_onehot;

  assign WriteReady   = (state_q != STROBE);
  assign ConfigBusy   = (state_q != IDLE);
  assign FrameData    = frame_rows_q;
  assign accept       = WriteValid && WriteReady;
  assign is_sync      = (WriteData == SYNC_WORD);
  assign hdr_end      = WriteData[31];
  assign hdr_index    = WriteData[4:0];
  assign hdr_index_ok = (32'(hdr_index) < 32'(MaxFramesPerCol));

  // NOTE: every signal written in always_comb gets a default first, otherwise
  // any path that skips the assignment infers a latch.
  always_comb begin
    strobe_onehot = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      strobe_onehot[i] = index_ok_q && (32'(index_q) == 32'(i));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      row_q        <= '0;
      index_q      <= '0;
      index_ok_q   <= 1'b0;
      FrameStrobe  <= '0;
      ConfigDone   <= 1'b0;
      ConfigError  <= 1'b0;
      // NOTE: the row storage is reset on purpose: downstream tiles must see
      // all-zero frame data after reset, so this is not left as uninitialised RAM.
      frame_rows_q <= '0;
    end else begin
      ConfigDone  <= 1'b0;
      FrameStrobe <= '0;
      case (state_q)
        IDLE: begin
          if (accept && is_sync) begin
            state_q     <= HEADER;
            ConfigError <= 1'b0;
          end
        end
        HEADER: begin
          if (accept && !is_sync) begin
            if (hdr_end) begin
              ConfigDone <= 1'b1;
              state_q    <= IDLE;
            end else begin
              index_q    <= hdr_index;
              index_ok_q <= hdr_index_ok;
              row_q      <= '0;
              state_q    <= DATA;
              if (!hdr_index_ok) ConfigError <= 1'b1;
            end
          end
        end
        DATA: begin
          // Sync words are ordinary payload here; only the row count ends a frame.
          if (accept) begin
            frame_rows_q[row_q] <= WriteData;
            if (row_q == LAST_ROW) begin
              row_q       <= '0;
              FrameStrobe <= strobe_onehot;
              state_q     <= STROBE;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= HEADER;
        end
      endcase
    end
  end

`ifdef FRAME_LOADER_FRAMECOUNT_EN
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      FramesWritten <= '0;
    end else if (state_q == IDLE && accept && is_sync) begin
      FramesWritten <= '0;
    end else if (|FrameStrobe && FramesWritten != 16'hFFFF) begin
      FramesWritten <= FramesWritten + 16'd1;
    end
  end
`endif

endmodule

// File: doc/frame_config_loader.md
FRAME_CONFIG_LOADER -- requirements
Module: frame_config_loader

Interface
REQ-001 SHALL have parameter FrameBitsPerRow, default 32: width of one row's frame data word.
REQ-002 SHALL have parameter MaxFramesPerCol, default 20: number of frame strobes per column.
REQ-003 SHALL have parameter NumberOfRows, default 16: number of rows (data words) per frame.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port CLK, input, 1: clock; all state changes on rising edge.
REQ-006 SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port WriteData, input, FrameBitsPerRow: bitstream word.
REQ-008 SHALL have port WriteValid, input, 1: WriteData valid.
REQ-009 SHALL have port WriteReady, output, 1: loader accepts a word; transfer when WriteValid and WriteReady are both high at a CLK edge.
REQ-010 SHALL have port FrameData, output, NumberOfRows*FrameBitsPerRow: row r occupies bits [r*FrameBitsPerRow +: FrameBitsPerRow].
REQ-011 SHALL have port FrameStrobe, output, MaxFramesPerCol: one-hot frame latch strobe to the column tiles.
REQ-012 SHALL have port ConfigBusy, output, 1: high whenever state is not IDLE.
REQ-013 SHALL have port ConfigDone, output, 1: one-cycle pulse at end of configuration.
REQ-014 SHALL have port ConfigError, output, 1: sticky error flag.

Function
REQ-015 SHALL implement states IDLE, HEADER, DATA, STROBE, all registered.
REQ-016 In IDLE, SHALL hold WriteReady high, discard words other than the sync word 0xFAB0_FAB1, and on sync go to HEADER and clear ConfigError.
REQ-017 In HEADER, SHALL hold WriteReady high and interpret the accepted word as: sync word -> stay in HEADER; bit 31 set -> pulse ConfigDone next cycle and go to IDLE; otherwise latch bits [4:0] as frame index, reset the row counter to 0 and go to DATA.
REQ-018 In DATA, SHALL hold WriteReady high and write accepted word k (k = 0..NumberOfRows-1) to FrameData row k; after word NumberOfRows-1 it SHALL go to STROBE; sync words in DATA SHALL be treated as data.
REQ-019 In STROBE, SHALL drive WriteReady low for exactly one cycle, assert FrameStrobe[index] for that cycle only, then return to HEADER.
REQ-020 If the latched index >= MaxFramesPerCol, SHALL set ConfigError and still consume NumberOfRows data words, with FrameStrobe remaining all-zero in STROBE.
REQ-021 FrameData SHALL hold its value from the last data word through the strobe cycle until overwritten by the next frame's data.
REQ-022 FrameStrobe SHALL never have more than one bit set; it is a registered output.
REQ-023 WriteValid low SHALL stall any state except STROBE without state or output change.
REQ-024 Frame latency from acceptance of the last data word to the FrameStrobe pulse SHALL be exactly one cycle.

Reset
REQ-025 On resetn low, SHALL immediately (asynchronously) go to IDLE, with FrameData = 0, FrameStrobe = 0, ConfigDone = 0, ConfigError = 0, and row counter = 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame without any strobe pulse; after release the loader SHALL require a new sync word.
REQ-027 WriteReady SHALL be high in IDLE on the first cycle after reset release.

Configuration
REQ-028 With macro FRAME_LOADER_FRAMECOUNT_EN defined, SHALL add output FramesWritten [15:0], which increments on every FrameStrobe pulse, saturates at 0xFFFF, and clears on reset and on a sync word accepted in IDLE.
REQ-029 Without FRAME_LOADER_FRAMECOUNT_EN, SHALL omit the FramesWritten port and counter logic entirely; all other behaviour is identical.

Verification
REQ-030 Reset, then send sync, header 0x0000_0003, and 16 words 0x1000_0000+k -> FrameData row k = 0x1000_0000+k, FrameStrobe = 0x00008 for one cycle, and WriteReady low in that cycle.
REQ-031 Send header 0x0000_0017 (index 23 >= 20) plus 16 data words -> ConfigError = 1, FrameStrobe stays 0, and the next header is accepted normally.
REQ-032 Send header 0x8000_0000 after one frame -> ConfigDone pulses for 1 cycle, ConfigBusy drops, and non-sync word 0x1234_5678 in IDLE is ignored.
REQ-033 Assert resetn low after data word 7 of a frame -> no strobe, all outputs 0; header sent without sync after release is ignored.
REQ-034 Toggle WriteValid randomly during DATA with 0xFAB0_FAB1 as data word 2 -> stalls are held, and row 2 = 0xFAB0_FAB1.
REQ-035 With FRAME_LOADER_FRAMECOUNT_EN, write 3 valid frames and 1 invalid-index frame -> FramesWritten = 3; a new sync from IDLE -> FramesWritten = 0.
